// File: rtl/memory_bank_dp.sv
// -----------------------------------------------------------------------------
// memory_bank_dp
// Simple-dual-port memory bank. One write port and one read port, both usable
// in the same cycle. Writes honour per-byte enables. A read returns its word
// READ_LATENCY cycles after it is accepted, marked by a one-cycle rd_valid
// strobe. After reset, a hardware sequencer writes INIT_VALUE to every word.
// While it runs, busy is high and all requests are ignored.
//
// Parameters
//   DATA_WIDTH   word width in bits (multiple of 8)
//   ADDR_WIDTH   address width, DEPTH = 2**ADDR_WIDTH
//   READ_LATENCY cycles from accepted read to rd_valid (1 or 2)
//   WRITE_FIRST  same-address collision: 1 = new data, 0 = old data
//   INIT_VALUE   word written everywhere by the init sequencer
//
// Ports
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   wr_en    write request         wr_addr  write address
//   wr_data  write data            wr_be    byte enables (bit i -> byte i)
//   rd_en    read request          rd_addr  read address
//   rd_data  read data, holds its value between strobes
//   rd_valid one-cycle strobe qualifying rd_data
//   busy     init sequencer running, requests ignored
// -----------------------------------------------------------------------------
module memory_bank_dp #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    ADDR_WIDTH   = 6,
  parameter int                    READ_LATENCY = 1,
  parameter int                    WRITE_FIRST  = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    busy
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_go;
  logic                    rd_go;
  logic                    init_go;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic [READ_LATENCY-1:0] pipe_vld;
  logic [DATA_WIDTH-1:0]   pipe_dat [READ_LATENCY];

  // ---------------------------------------------------------------------------
  // Control FSM: INIT sweeps every address once, then RUN forever.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
      end
    end
  end

  // NOTE: the default assignment at the top of the block keeps every path
  // assigned, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (init_cnt == ADDR_WIDTH'(DEPTH - 1)) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // busy is a direct decode of the state flop, so it is still a registered
  // output with no path from any input.
  assign busy = (state == ST_INIT);

  // Requests are qualified by rst_n so nothing commits on a reset edge.
  assign init_go = rst_n && (state == ST_INIT);
  assign wr_go   = rst_n && (state == ST_RUN) && wr_en;
  assign rd_go   = rst_n && (state == ST_RUN) && rd_en;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch; clearing it is the init sequencer's
  // job. A reset here would turn the RAM into thousands of flops.
  always_ff @(posedge clk) begin
    if (init_go) begin
      mem[init_cnt] <= INIT_VALUE;
    end else if (wr_go) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wr_be[b]) begin
          mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Word captured by an accepted read. The array read returns the pre-edge
  // contents, which is the old-data result. Write-first merges the enabled
  // bytes of a same-address write on top.
  always_comb begin
    rd_word = mem[rd_addr];
    if ((WRITE_FIRST != 0) && wr_go && (wr_addr == rd_addr)) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wr_be[b]) begin
          rd_word[8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline: stage 0 captures at the accept edge, and the output
  // register fires READ_LATENCY edges later. Valid bits are reset so
  // in-flight reads vanish on reset. Data stages need no reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rd_go) begin
      pipe_dat[0] <= rd_word;
    end
    for (int s = 1; s < READ_LATENCY; s++) begin
      pipe_dat[s] <= pipe_dat[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      pipe_vld[0] <= rd_go;
      for (int s = 1; s < READ_LATENCY; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
      end
      rd_valid <= pipe_vld[READ_LATENCY-1];
      if (pipe_vld[READ_LATENCY-1]) begin
        rd_data <= pipe_dat[READ_LATENCY-1];
      end
    end
  end

endmodule

// File: tb/tb_memory_bank_dp.sv
// -----------------------------------------------------------------------------
// tb_memory_bank_dp
// Two instances share one stimulus stream:
//   dut_a: 16-bit words, READ_LATENCY=2, old-data collisions, INIT 16'h5A5A
//   dut_b:  8-bit words, READ_LATENCY=1, new-data collisions, INIT 8'h5A
// The driver pushes hand-computed expected words plus their due cycle into
// per-instance queues. A monitor on the falling edge pops on every rd_valid.
// -----------------------------------------------------------------------------
module tb_memory_bank_dp;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        rd_en;
  logic [5:0]  rd_addr;

  logic [15:0] rd_data_a;
  logic        rd_valid_a;
  logic        busy_a;
  logic [7:0]  rd_data_b;
  logic        rd_valid_b;
  logic        busy_b;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  memory_bank_dp #(
    .DATA_WIDTH(16), .ADDR_WIDTH(6), .READ_LATENCY(LAT_A),
    .WRITE_FIRST(0), .INIT_VALUE(16'h5A5A)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .busy(busy_a)
  );

  memory_bank_dp #(
    .DATA_WIDTH(8), .ADDR_WIDTH(6), .READ_LATENCY(LAT_B),
    .WRITE_FIRST(1), .INIT_VALUE(8'h5A)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[7:0]), .wr_be(wr_be[0:0]),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .busy(busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every strobe must match the head of its queue, both
  // in data and in the cycle it arrives.
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid_a === 1'b1) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_valid: got rd_valid=1 data %h expected no read (cycle %0d)", rd_data_a, cyc);
      end else begin
        e = q_a.pop_front();
        check("a_data", 32'(rd_data_a), 32'(e.data));
        check("a_cycle", cyc, e.due);
      end
    end
    if (rd_valid_b === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_valid: got rd_valid=1 data %h expected no read (cycle %0d)", rd_data_b, cyc);
      end else begin
        e = q_b.pop_front();
        check("b_data", 32'(rd_data_b), 32'(e.data[7:0]));
        check("b_cycle", cyc, e.due);
      end
    end
  end

  // One cycle of stimulus, called at a falling edge. A read pushes its
  // expectation, due READ_LATENCY edges after the accepting edge.
  task automatic drive(input logic we, input logic [5:0] wa, input logic [15:0] wd,
                       input logic [1:0] be, input logic re, input logic [5:0] ra,
                       input logic [15:0] ea, input logic [7:0] eb);
    exp_t e;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra;
    if (re) begin
      e.data = ea;          e.due = cyc + 1 + LAT_A; q_a.push_back(e);
      e.data = {8'h00, eb}; e.due = cyc + 1 + LAT_B; q_b.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0; rd_en = 1'b0; wr_be = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    repeat (n) @(negedge clk);
  endtask

  // Counts the edges that see busy high, starting at the falling edge where
  // reset was released. The count is bounded so a stuck busy still ends.
  task automatic wait_init(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy_a !== 1'b1) break;
      n++;
      @(negedge clk);
    end
    check(name, n, 64);
    check({name, "_b"}, 32'(busy_b), 32'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle(3);
    check("rst_busy_a",  32'(busy_a), 1);
    check("rst_valid_a", 32'(rd_valid_a), 0);
    check("rst_data_a",  32'(rd_data_a), 0);
    check("rst_busy_b",  32'(busy_b), 1);
    check("rst_valid_b", 32'(rd_valid_b), 0);
    check("rst_data_b",  32'(rd_data_b), 0);

    // Hold a write of FFFF to addr 0 and a read of addr 0 through all of init.
    // Neither may take effect.
    wr_en = 1'b1; wr_addr = 6'd0; wr_data = 16'hFFFF; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 6'd0;
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("mid_init_busy", 32'(busy_a), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init_after_mid_reset");
    idle(1);

    // Every word holds INIT_VALUE, including addr 0, which saw the ignored
    // write.
    for (int k = 0; k < 64; k++) drive(1'b0, '0, '0, '0, 1'b1, 6'(k), 16'h5A5A, 8'h5A);
    idle(4);

    // Byte enables, then a no-op write colliding with a read.
    drive(1'b1, 6'd3, 16'hAABB, 2'b11, 1'b0, '0, '0, '0);
    drive(1'b1, 6'd3, 16'h1122, 2'b01, 1'b0, '0, '0, '0);
    drive(1'b1, 6'd3, 16'hFFFF, 2'b00, 1'b1, 6'd3, 16'hAA22, 8'h22);
    drive(1'b0, '0, '0, '0, 1'b1, 6'd3, 16'hAA22, 8'h22);
    idle(4);

    // Preload k at addr k, then stream reads 0..7 while writing other words.
    for (int k = 0; k < 8; k++) drive(1'b1, 6'(k), 16'(k), 2'b11, 1'b0, '0, '0, '0);
    for (int k = 0; k < 8; k++)
      drive(1'b1, 6'(16 + k), 16'h00C0 + 16'(k), 2'b11, 1'b1, 6'(k), 16'(k), 8'(k));
    for (int k = 0; k < 8; k++)
      drive(1'b0, '0, '0, '0, 1'b1, 6'(16 + k), 16'h00C0 + 16'(k), 8'hC0 + 8'(k));
    idle(5);
    check("hold_valid_a", 32'(rd_valid_a), 0);
    check("hold_data_a",  32'(rd_data_a), 32'h00C7);
    check("hold_data_b",  32'(rd_data_b), 32'hC7);

    // Collision at addr 5: dut_a returns old data, dut_b returns new data.
    drive(1'b1, 6'd5, 16'h3311, 2'b11, 1'b0, '0, '0, '0);
    drive(1'b1, 6'd5, 16'h4422, 2'b01, 1'b1, 6'd5, 16'h3311, 8'h22);
    drive(1'b0, '0, '0, '0, 1'b1, 6'd5, 16'h3322, 8'h22);
    idle(4);

    // Reset while a read is in flight in both instances. No expectation is
    // pushed, so any late strobe is flagged by the monitor.
    rd_en = 1'b1; rd_addr = 6'd6;
    @(negedge clk);
    rst_n = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    check("rst_read_valid_a", 32'(rd_valid_a), 0);
    check("rst_read_data_a",  32'(rd_data_a), 0);
    check("rst_read_valid_b", 32'(rd_valid_b), 0);
    check("rst_read_data_b",  32'(rd_data_b), 0);
    rst_n = 1'b1;
    wait_init("init_after_read_reset");
    drive(1'b0, '0, '0, '0, 1'b1, 6'd3, 16'h5A5A, 8'h5A);
    idle(6);

    check("drain_a", q_a.size(), 0);
    check("drain_b", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
